// File: rtl/z80fi_trace_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_trace_collector_pkg
// Description : Shared z80fi constants, register-number encoding, FSM states
//               and the per-instruction capture record. Z80FI_MEM_RD2_EN adds
//               a second memory-read slot to the capture record.
// Revision    : 1.0 - initial release
// ============================================================================
package z80fi_trace_collector_pkg;

    localparam int c_MAX_LEN = 4;
    localparam int c_INSN_W  = 32;
    localparam int c_LANES   = c_INSN_W / 8;
    localparam int c_LEN_W   = 3;

    // Register-pair numbers share the z80fi_reg_wnum encoding {2'b10, dd}
    localparam logic [1:0] c_REG_PAIR_PFX = 2'b10;
    localparam logic [3:0] c_REG_BC       = {c_REG_PAIR_PFX, 2'b00};
    localparam logic [3:0] c_REG_DE       = {c_REG_PAIR_PFX, 2'b01};
    localparam logic [3:0] c_REG_HL       = {c_REG_PAIR_PFX, 2'b10};
    localparam logic [3:0] c_REG_SP       = {c_REG_PAIR_PFX, 2'b11};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] pc_rdata;
        logic        reg_wr;
        logic [3:0]  reg_wnum;
        logic [15:0] reg_wdata;
        logic        mem_rd;
        logic [15:0] mem_raddr;
        logic [7:0]  mem_rdata;
`ifdef Z80FI_MEM_RD2_EN
        logic        mem_rd2;
        logic [15:0] mem_raddr2;
        logic [7:0]  mem_rdata2;
`endif
        logic        mem_wr;
        logic [15:0] mem_waddr;
        logic [7:0]  mem_wdata;
    } capture_t;

    function automatic logic [3:0] reg_pair_num(input logic [1:0] dd);
        return {c_REG_PAIR_PFX, dd};
    endfunction

endpackage : z80fi_trace_collector_pkg
`default_nettype wire

// File: rtl/z80fi_trace_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_trace_collector_if
// Description : Core event inputs and z80fi packet outputs of the trace
//               collector. Z80FI_MEM_RD2_EN adds the second-read packet fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface z80fi_trace_collector_if;

    logic        fetch_valid;
    logic [7:0]  fetch_data;
    logic [15:0] fetch_pc;
    logic        reg_wr_valid;
    logic [3:0]  reg_wr_num;
    logic [15:0] reg_wr_data;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        mem_wr_valid;
    logic [15:0] mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        retire;
    logic [15:0] retire_next_pc;

    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata;
    logic [15:0] z80fi_pc_wdata;
    logic        z80fi_reg_wr;
    logic [3:0]  z80fi_reg_wnum;
    logic [15:0] z80fi_reg_wdata;
    logic        z80fi_mem_rd;
    logic [15:0] z80fi_mem_raddr;
    logic [7:0]  z80fi_mem_rdata;
`ifdef Z80FI_MEM_RD2_EN
    logic        z80fi_mem_rd2;
    logic [15:0] z80fi_mem_raddr2;
    logic [7:0]  z80fi_mem_rdata2;
`endif
    logic        z80fi_mem_wr;
    logic [15:0] z80fi_mem_waddr;
    logic [7:0]  z80fi_mem_wdata;
    logic        z80fi_error;

    modport master (
        output fetch_valid, fetch_data, fetch_pc,
        output reg_wr_valid, reg_wr_num, reg_wr_data,
        output mem_rd_valid, mem_rd_addr, mem_rd_data,
        output mem_wr_valid, mem_wr_addr, mem_wr_data,
        output retire, retire_next_pc,
        input  z80fi_valid, z80fi_insn, z80fi_insn_len,
        input  z80fi_pc_rdata, z80fi_pc_wdata,
        input  z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata,
        input  z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata,
`ifdef Z80FI_MEM_RD2_EN
        input  z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2,
`endif
        input  z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata,
        input  z80fi_error
    );

    modport slave (
        input  fetch_valid, fetch_data, fetch_pc,
        input  reg_wr_valid, reg_wr_num, reg_wr_data,
        input  mem_rd_valid, mem_rd_addr, mem_rd_data,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data,
        input  retire, retire_next_pc,
        output z80fi_valid, z80fi_insn, z80fi_insn_len,
        output z80fi_pc_rdata, z80fi_pc_wdata,
        output z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata,
        output z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata,
`ifdef Z80FI_MEM_RD2_EN
        output z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2,
`endif
        output z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata,
        output z80fi_error
    );

endinterface : z80fi_trace_collector_if
`default_nettype wire

// File: rtl/z80fi_trace_collector_insn_accum.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_insn_accum
// Description : Byte-lane accumulator for instruction bytes; exposes the
//               post-fetch image so a retiring fetch lands in the packet.
// Revision    : 1.0 - initial release
// ============================================================================
module z80fi_insn_accum
    import z80fi_trace_collector_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 i_clear,
    input  wire                 i_byte_valid,
    input  wire  [7:0]          i_byte_data,
    output logic [c_INSN_W-1:0] o_insn_nxt,
    output logic [c_LEN_W-1:0]  o_len_nxt,
    output logic                o_overflow
);

    logic [c_INSN_W-1:0] r_insn;
    logic [c_LEN_W-1:0]  r_len;

    // A byte arriving with the buffer full is dropped and the count saturates
    always_comb begin
        o_insn_nxt = r_insn;
        o_len_nxt  = r_len;
        o_overflow = 1'b0;
        if (i_byte_valid) begin
            if (r_len >= c_LEN_W'(MAX_LEN)) begin
                o_overflow = 1'b1;
            end else begin
                for (int i = 0; i < c_LANES; i++) begin
                    if (r_len == c_LEN_W'(i)) begin
                        o_insn_nxt[i*8 +: 8] = i_byte_data;
                    end
                end
                o_len_nxt = r_len + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_insn <= '0;
            r_len  <= '0;
        end else begin
            r_insn <= o_insn_nxt;
            r_len  <= o_len_nxt;
        end
    end

endmodule : z80fi_insn_accum
`default_nettype wire

// File: rtl/z80fi_trace_collector.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_trace_collector
// Description : Collects the fetch/register/memory events of one instruction
//               and emits a single-cycle z80fi packet after retirement.
//               Z80FI_MEM_RD2_EN captures a second data read per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module z80fi_trace_collector
    import z80fi_trace_collector_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN
) (
    input  wire                    clk,
    input  wire                    reset,
    z80fi_trace_collector_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_emit;
    logic                w_err_nxt;
    logic                r_error;
    capture_t            r_cap;
    capture_t            w_cap;

    logic [c_INSN_W-1:0] w_insn_nxt;
    logic [c_LEN_W-1:0]  w_len_nxt;
    logic                w_overflow;

    logic                r_pkt_valid;
    logic [c_INSN_W-1:0] r_pkt_insn;
    logic [c_LEN_W-1:0]  r_pkt_len;
    logic [15:0]         r_pkt_pc_wdata;
    capture_t            r_pkt_cap;
    capture_t            w_pkt_cap;

    z80fi_insn_accum #(
        .MAX_LEN (MAX_LEN)
    ) u_accum (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (bus.retire),
        .i_byte_valid (bus.fetch_valid),
        .i_byte_data  (bus.fetch_data),
        .o_insn_nxt   (w_insn_nxt),
        .o_len_nxt    (w_len_nxt),
        .o_overflow   (w_overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A retire with no byte ever fetched has nothing to report
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.retire) begin
                    w_emit = bus.fetch_valid;
                end else if (bus.fetch_valid) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.retire) begin
                    w_emit      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture view including this cycle's events; first event of each kind wins
    always_comb begin
        w_cap     = r_cap;
        w_err_nxt = r_error;

        if (r_state == ST_IDLE && bus.fetch_valid) begin
            w_cap.pc_rdata = bus.fetch_pc;
        end

        if (bus.reg_wr_valid) begin
            if (r_cap.reg_wr) begin
                w_err_nxt = 1'b1;
            end else begin
                w_cap.reg_wr    = 1'b1;
                w_cap.reg_wnum  = bus.reg_wr_num;
                w_cap.reg_wdata = bus.reg_wr_data;
            end
        end

        if (bus.mem_rd_valid) begin
            if (!r_cap.mem_rd) begin
                w_cap.mem_rd    = 1'b1;
                w_cap.mem_raddr = bus.mem_rd_addr;
                w_cap.mem_rdata = bus.mem_rd_data;
            end
`ifdef Z80FI_MEM_RD2_EN
            else if (!r_cap.mem_rd2) begin
                w_cap.mem_rd2    = 1'b1;
                w_cap.mem_raddr2 = bus.mem_rd_addr;
                w_cap.mem_rdata2 = bus.mem_rd_data;
            end
`endif
            else begin
                w_err_nxt = 1'b1;
            end
        end

        if (bus.mem_wr_valid) begin
            if (r_cap.mem_wr) begin
                w_err_nxt = 1'b1;
            end else begin
                w_cap.mem_wr    = 1'b1;
                w_cap.mem_waddr = bus.mem_wr_addr;
                w_cap.mem_wdata = bus.mem_wr_data;
            end
        end

        if (w_overflow) begin
            w_err_nxt = 1'b1;
        end

        if (bus.retire && r_state == ST_IDLE && !bus.fetch_valid) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error        <= 1'b0;
            r_cap          <= '0;
            r_pkt_valid    <= 1'b0;
            r_pkt_insn     <= '0;
            r_pkt_len      <= '0;
            r_pkt_pc_wdata <= '0;
            r_pkt_cap      <= '0;
        end else begin
            r_error        <= w_err_nxt;
            r_cap          <= bus.retire ? '0 : w_cap;
            r_pkt_valid    <= w_emit;
            r_pkt_insn     <= w_emit ? w_insn_nxt : '0;
            r_pkt_len      <= w_emit ? w_len_nxt : '0;
            r_pkt_pc_wdata <= w_emit ? bus.retire_next_pc : '0;
            r_pkt_cap      <= w_emit ? w_cap : '0;
        end
    end

    // Reset also masks the registered packet so a packet due in a reset cycle is dropped
    assign w_pkt_cap = reset ? '0 : r_pkt_cap;

    assign bus.z80fi_valid      = r_pkt_valid & ~reset;
    assign bus.z80fi_insn       = reset ? '0 : r_pkt_insn;
    assign bus.z80fi_insn_len   = reset ? '0 : r_pkt_len;
    assign bus.z80fi_pc_wdata   = reset ? '0 : r_pkt_pc_wdata;
    assign bus.z80fi_pc_rdata   = w_pkt_cap.pc_rdata;
    assign bus.z80fi_reg_wr     = w_pkt_cap.reg_wr;
    assign bus.z80fi_reg_wnum   = w_pkt_cap.reg_wnum;
    assign bus.z80fi_reg_wdata  = w_pkt_cap.reg_wdata;
    assign bus.z80fi_mem_rd     = w_pkt_cap.mem_rd;
    assign bus.z80fi_mem_raddr  = w_pkt_cap.mem_raddr;
    assign bus.z80fi_mem_rdata  = w_pkt_cap.mem_rdata;
`ifdef Z80FI_MEM_RD2_EN
    assign bus.z80fi_mem_rd2    = w_pkt_cap.mem_rd2;
    assign bus.z80fi_mem_raddr2 = w_pkt_cap.mem_raddr2;
    assign bus.z80fi_mem_rdata2 = w_pkt_cap.mem_rdata2;
`endif
    assign bus.z80fi_mem_wr     = w_pkt_cap.mem_wr;
    assign bus.z80fi_mem_waddr  = w_pkt_cap.mem_waddr;
    assign bus.z80fi_mem_wdata  = w_pkt_cap.mem_wdata;
    assign bus.z80fi_error      = r_error & ~reset;

endmodule : z80fi_trace_collector
`default_nettype wire

// File: tb/tb_z80fi_trace_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80fi_trace_collector
// Description : Directed vector table plus randomized traffic against a
//               queue-based model of the z80fi trace collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z80fi_trace_collector;

    typedef struct packed {
        logic        reset;
        logic        fetch_valid;
        logic [7:0]  fetch_data;
        logic [15:0] fetch_pc;
        logic        reg_wr_valid;
        logic [3:0]  reg_wr_num;
        logic [15:0] reg_wr_data;
        logic        mem_rd_valid;
        logic [15:0] mem_rd_addr;
        logic [7:0]  mem_rd_data;
        logic        mem_wr_valid;
        logic [15:0] mem_wr_addr;
        logic [7:0]  mem_wr_data;
        logic        retire;
        logic [15:0] retire_next_pc;
    } tb_in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] pc_rdata;
        logic [15:0] pc_wdata;
        logic        reg_wr;
        logic [3:0]  reg_wnum;
        logic [15:0] reg_wdata;
        logic        mem_rd;
        logic [15:0] mem_raddr;
        logic [7:0]  mem_rdata;
        logic        mem_rd2;
        logic [15:0] mem_raddr2;
        logic [7:0]  mem_rdata2;
        logic        mem_wr;
        logic [15:0] mem_waddr;
        logic [7:0]  mem_wdata;
        logic        error;
    } tb_pkt_t;

    typedef struct {
        tb_in_t  in;
        tb_pkt_t exp;
    } vec_t;

    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic rst_s;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    z80fi_trace_collector_if bus ();

    z80fi_trace_collector dut (
        .clk   (clk),
        .reset (rst_s),
        .bus   (bus)
    );

    task automatic drive(tb_in_t v);
        rst_s              = v.reset;
        bus.fetch_valid    = v.fetch_valid;
        bus.fetch_data     = v.fetch_data;
        bus.fetch_pc       = v.fetch_pc;
        bus.reg_wr_valid   = v.reg_wr_valid;
        bus.reg_wr_num     = v.reg_wr_num;
        bus.reg_wr_data    = v.reg_wr_data;
        bus.mem_rd_valid   = v.mem_rd_valid;
        bus.mem_rd_addr    = v.mem_rd_addr;
        bus.mem_rd_data    = v.mem_rd_data;
        bus.mem_wr_valid   = v.mem_wr_valid;
        bus.mem_wr_addr    = v.mem_wr_addr;
        bus.mem_wr_data    = v.mem_wr_data;
        bus.retire         = v.retire;
        bus.retire_next_pc = v.retire_next_pc;
    endtask

    function automatic tb_pkt_t sample();
        tb_pkt_t a;
        a = '0;
        a.valid     = bus.z80fi_valid;
        a.insn      = bus.z80fi_insn;
        a.len       = bus.z80fi_insn_len;
        a.pc_rdata  = bus.z80fi_pc_rdata;
        a.pc_wdata  = bus.z80fi_pc_wdata;
        a.reg_wr    = bus.z80fi_reg_wr;
        a.reg_wnum  = bus.z80fi_reg_wnum;
        a.reg_wdata = bus.z80fi_reg_wdata;
        a.mem_rd    = bus.z80fi_mem_rd;
        a.mem_raddr = bus.z80fi_mem_raddr;
        a.mem_rdata = bus.z80fi_mem_rdata;
`ifdef Z80FI_MEM_RD2_EN
        a.mem_rd2    = bus.z80fi_mem_rd2;
        a.mem_raddr2 = bus.z80fi_mem_raddr2;
        a.mem_rdata2 = bus.z80fi_mem_rdata2;
`endif
        a.mem_wr    = bus.z80fi_mem_wr;
        a.mem_waddr = bus.z80fi_mem_waddr;
        a.mem_wdata = bus.z80fi_mem_wdata;
        a.error     = bus.z80fi_error;
        return a;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, tb_pkt_t e);
        tb_pkt_t a;
        a = sample();
        chk({tag, ".valid"},     32'(a.valid),     32'(e.valid));
        chk({tag, ".insn"},      a.insn,           e.insn);
        chk({tag, ".len"},       32'(a.len),       32'(e.len));
        chk({tag, ".pc_rdata"},  32'(a.pc_rdata),  32'(e.pc_rdata));
        chk({tag, ".pc_wdata"},  32'(a.pc_wdata),  32'(e.pc_wdata));
        chk({tag, ".reg_wr"},    32'(a.reg_wr),    32'(e.reg_wr));
        chk({tag, ".reg_wnum"},  32'(a.reg_wnum),  32'(e.reg_wnum));
        chk({tag, ".reg_wdata"}, 32'(a.reg_wdata), 32'(e.reg_wdata));
        chk({tag, ".mem_rd"},    32'(a.mem_rd),    32'(e.mem_rd));
        chk({tag, ".mem_raddr"}, 32'(a.mem_raddr), 32'(e.mem_raddr));
        chk({tag, ".mem_rdata"}, 32'(a.mem_rdata), 32'(e.mem_rdata));
`ifdef Z80FI_MEM_RD2_EN
        chk({tag, ".mem_rd2"},    32'(a.mem_rd2),    32'(e.mem_rd2));
        chk({tag, ".mem_raddr2"}, 32'(a.mem_raddr2), 32'(e.mem_raddr2));
        chk({tag, ".mem_rdata2"}, 32'(a.mem_rdata2), 32'(e.mem_rdata2));
`endif
        chk({tag, ".mem_wr"},    32'(a.mem_wr),    32'(e.mem_wr));
        chk({tag, ".mem_waddr"}, 32'(a.mem_waddr), 32'(e.mem_waddr));
        chk({tag, ".mem_wdata"}, 32'(a.mem_wdata), 32'(e.mem_wdata));
        chk({tag, ".error"},     32'(a.error),     32'(e.error));
    endtask

    // Inputs applied just after the edge; outputs observed mid-cycle
    task automatic cycle(tb_in_t v, tb_pkt_t e, string tag);
        @(posedge clk);
        #1;
        drive(v);
        #3;
        cmp(tag, e);
    endtask

    function automatic tb_in_t fe(logic [7:0] d, logic [15:0] pc);
        tb_in_t v;
        v = '0;
        v.fetch_valid = 1'b1;
        v.fetch_data  = d;
        v.fetch_pc    = pc;
        return v;
    endfunction

    task automatic add(tb_in_t v, tb_pkt_t e);
        vec_t x;
        x.in  = v;
        x.exp = e;
        tbl.push_back(x);
    endtask

    // Reference model: byte queue plus per-kind event counters
    logic [7:0]  m_q[$];
    logic [15:0] m_pc0;
    int          m_reg_n, m_rd_n, m_wr_n;
    tb_pkt_t     m_cap;
    logic        m_err;
    tb_pkt_t     m_out;

    task automatic model_clear();
        m_q.delete();
        m_pc0   = '0;
        m_reg_n = 0;
        m_rd_n  = 0;
        m_wr_n  = 0;
        m_cap   = '0;
    endtask

    task automatic model_step(tb_in_t v, output tb_pkt_t exp);
        tb_pkt_t p;
        int      rd_limit;
        exp = v.reset ? '0 : m_out;
`ifdef Z80FI_MEM_RD2_EN
        rd_limit = 2;
`else
        rd_limit = 1;
`endif
        if (v.reset) begin
            model_clear();
            m_err = 1'b0;
            m_out = '0;
        end else begin
            if (v.fetch_valid) begin
                if (m_q.size() == 0) m_pc0 = v.fetch_pc;
                if (m_q.size() < MAXL) m_q.push_back(v.fetch_data);
                else m_err = 1'b1;
            end
            if (v.reg_wr_valid) begin
                if (m_reg_n == 0) begin
                    m_cap.reg_wr    = 1'b1;
                    m_cap.reg_wnum  = v.reg_wr_num;
                    m_cap.reg_wdata = v.reg_wr_data;
                end
                m_reg_n++;
                if (m_reg_n > 1) m_err = 1'b1;
            end
            if (v.mem_rd_valid) begin
                if (m_rd_n == 0) begin
                    m_cap.mem_rd    = 1'b1;
                    m_cap.mem_raddr = v.mem_rd_addr;
                    m_cap.mem_rdata = v.mem_rd_data;
                end else if (m_rd_n == 1 && rd_limit == 2) begin
                    m_cap.mem_rd2    = 1'b1;
                    m_cap.mem_raddr2 = v.mem_rd_addr;
                    m_cap.mem_rdata2 = v.mem_rd_data;
                end
                m_rd_n++;
                if (m_rd_n > rd_limit) m_err = 1'b1;
            end
            if (v.mem_wr_valid) begin
                if (m_wr_n == 0) begin
                    m_cap.mem_wr    = 1'b1;
                    m_cap.mem_waddr = v.mem_wr_addr;
                    m_cap.mem_wdata = v.mem_wr_data;
                end
                m_wr_n++;
                if (m_wr_n > 1) m_err = 1'b1;
            end
            p = '0;
            if (v.retire) begin
                if (m_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    p          = m_cap;
                    p.valid    = 1'b1;
                    p.len      = 3'(m_q.size());
                    p.pc_rdata = m_pc0;
                    p.pc_wdata = v.retire_next_pc;
                    for (int i = 0; i < m_q.size(); i++) p.insn[i*8 +: 8] = m_q[i];
                end
                model_clear();
            end
            p.error = m_err;
            m_out   = p;
        end
    endtask

    function automatic bit chance(int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    initial begin
        tb_in_t  v, z, rs;
        tb_pkt_t e0, ee, e;
        logic [15:0] rpc;

        z  = '0;
        rs = '0;
        rs.reset = 1'b1;
        e0 = '0;
        ee = '0;
        ee.error = 1'b1;
        drive(rs);

        add(rs, e0);
        add(rs, e0);
        // Three-byte instruction with a register-pair write
        add(fe(8'h01, 16'h0100), e0);
        v = fe(8'h34, 16'h0101); v.reg_wr_valid = 1'b1; v.reg_wr_num = 4'b1000; v.reg_wr_data = 16'h1234;
        add(v, e0);
        v = fe(8'h12, 16'h0102); v.retire = 1'b1; v.retire_next_pc = 16'h0103;
        add(v, e0);
        e = e0; e.valid = 1'b1; e.insn = 32'h00123401; e.len = 3'd3; e.pc_rdata = 16'h0100;
        e.pc_wdata = 16'h0103; e.reg_wr = 1'b1; e.reg_wnum = 4'h8; e.reg_wdata = 16'h1234;
        add(z, e);
        add(z, e0);
        // Fetch and retire in the same cycle
        v = fe(8'h00, 16'h0200); v.retire = 1'b1; v.retire_next_pc = 16'h0201;
        add(v, e0);
        e = e0; e.valid = 1'b1; e.len = 3'd1; e.pc_rdata = 16'h0200; e.pc_wdata = 16'h0201;
        add(z, e);
        // Fifth byte overflows
        add(fe(8'hDD, 16'h0300), e0);
        add(fe(8'hCB, 16'h0301), e0);
        add(fe(8'h05, 16'h0302), e0);
        add(fe(8'hC6, 16'h0303), e0);
        add(fe(8'h77, 16'h0304), e0);
        v = z; v.retire = 1'b1; v.retire_next_pc = 16'h0304;
        add(v, ee);
        e = ee; e.valid = 1'b1; e.insn = 32'hC605CBDD; e.len = 3'd4; e.pc_rdata = 16'h0300; e.pc_wdata = 16'h0304;
        add(z, e);
        add(rs, e0);
        // Double memory write keeps the first
        v = fe(8'h00, 16'h0400); v.mem_wr_valid = 1'b1; v.mem_wr_addr = 16'h8000; v.mem_wr_data = 8'hAA;
        add(v, e0);
        v = z; v.mem_wr_valid = 1'b1; v.mem_wr_addr = 16'h8001; v.mem_wr_data = 8'hBB;
        add(v, e0);
        v = z; v.retire = 1'b1; v.retire_next_pc = 16'h0401;
        add(v, ee);
        e = ee; e.valid = 1'b1; e.len = 3'd1; e.pc_rdata = 16'h0400; e.pc_wdata = 16'h0401;
        e.mem_wr = 1'b1; e.mem_waddr = 16'h8000; e.mem_wdata = 8'hAA;
        add(z, e);
        add(rs, e0);
        // Back-to-back instructions
        add(fe(8'h3E, 16'h0500), e0);
        v = fe(8'h42, 16'h0501); v.mem_rd_valid = 1'b1; v.mem_rd_addr = 16'h9000; v.mem_rd_data = 8'h55;
        v.retire = 1'b1; v.retire_next_pc = 16'h0502;
        add(v, e0);
        v = fe(8'h00, 16'h0502); v.retire = 1'b1; v.retire_next_pc = 16'h0503;
        e = e0; e.valid = 1'b1; e.insn = 32'h0000423E; e.len = 3'd2; e.pc_rdata = 16'h0500; e.pc_wdata = 16'h0502;
        e.mem_rd = 1'b1; e.mem_raddr = 16'h9000; e.mem_rdata = 8'h55;
        add(v, e);
        e = e0; e.valid = 1'b1; e.len = 3'd1; e.pc_rdata = 16'h0502; e.pc_wdata = 16'h0503;
        add(z, e);
        add(z, e0);
        // Reset mid-instruction, held through the retire
        add(fe(8'h01, 16'h0600), e0);
        add(fe(8'h02, 16'h0601), e0);
        add(rs, e0);
        v = rs; v.retire = 1'b1; v.retire_next_pc = 16'h0603;
        add(v, e0);
        add(z, e0);
        add(z, e0);
        // Reset in the packet cycle suppresses it
        v = fe(8'h00, 16'h0700); v.retire = 1'b1; v.retire_next_pc = 16'h0701;
        add(v, e0);
        add(rs, e0);
        add(z, e0);
        // Retire with nothing fetched
        v = z; v.retire = 1'b1; v.retire_next_pc = 16'h0800;
        add(v, e0);
        add(z, ee);
        add(rs, e0);
        // Two data reads
        v = fe(8'h00, 16'h0900); v.mem_rd_valid = 1'b1; v.mem_rd_addr = 16'hA000; v.mem_rd_data = 8'h11;
        add(v, e0);
        v = z; v.mem_rd_valid = 1'b1; v.mem_rd_addr = 16'hA001; v.mem_rd_data = 8'h22;
        v.retire = 1'b1; v.retire_next_pc = 16'h0901;
        add(v, e0);
`ifdef Z80FI_MEM_RD2_EN
        e = e0; e.mem_rd2 = 1'b1; e.mem_raddr2 = 16'hA001; e.mem_rdata2 = 8'h22;
`else
        e = ee;
`endif
        e.valid = 1'b1; e.len = 3'd1; e.pc_rdata = 16'h0900; e.pc_wdata = 16'h0901;
        e.mem_rd = 1'b1; e.mem_raddr = 16'hA000; e.mem_rdata = 8'h11;
        add(z, e);
        add(rs, e0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Randomized traffic
        m_err = 1'b0;
        m_out = '0;
        model_clear();
        rpc = 16'h1000;
        for (int c = 0; c < 3000; c++) begin
            v = '0;
            v.reset          = (c == 0) || chance(2);
            v.fetch_valid    = chance(50);
            v.fetch_data     = 8'($urandom);
            v.fetch_pc       = rpc;
            v.reg_wr_valid   = chance(12);
            v.reg_wr_num     = 4'($urandom);
            v.reg_wr_data    = 16'($urandom);
            v.mem_rd_valid   = chance(15);
            v.mem_rd_addr    = 16'($urandom);
            v.mem_rd_data    = 8'($urandom);
            v.mem_wr_valid   = chance(10);
            v.mem_wr_addr    = 16'($urandom);
            v.mem_wr_data    = 8'($urandom);
            v.retire         = (m_q.size() != 0 || v.fetch_valid) ? chance(35) : chance(3);
            v.retire_next_pc = 16'($urandom);
            if (v.fetch_valid) rpc = rpc + 16'd1;
            model_step(v, e);
            cycle(v, e, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_z80fi_trace_collector
`default_nettype wire

// File: doc/z80fi_trace_collector.md
Name: z80fi_trace_collector

Overview:
Producer side of the z80fi formal interface. Sits beside the CPU core and records the events of one instruction: opcode/operand byte fetches, register write, memory reads and writes. At retirement it emits a single-cycle z80fi_valid packet carrying those events, which the z80fi_insn_spec_* checkers consume.

Parameters:
MAX_LEN, 4, maximum instruction length in bytes (Z80 worst case, prefixed DD CB d op).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  core fetched one instruction byte this cycle
fetch_data  in  8  fetched byte
fetch_pc  in  16  address of fetched byte
reg_wr_valid  in  1  core wrote a register this instruction
reg_wr_num  in  4  register number, same encoding as z80fi_reg_wnum
reg_wr_data  in  16  written value
mem_rd_valid  in  1  data read strobe
mem_rd_addr  in  16  read address
mem_rd_data  in  8  read byte
mem_wr_valid  in  1  data write strobe
mem_wr_addr  in  16  write address
mem_wr_data  in  8  written byte
retire  in  1  current instruction completes this cycle
retire_next_pc  in  16  PC after this instruction
z80fi_valid  out  1  one-cycle packet strobe
z80fi_insn  out  32  instruction bytes, little-endian: first byte [7:0]
z80fi_insn_len  out  3  byte count, 1..MAX_LEN
z80fi_pc_rdata  out  16  address of first byte
z80fi_pc_wdata  out  16  retire_next_pc
z80fi_reg_wr / z80fi_reg_wnum / z80fi_reg_wdata  out  1/4/16  captured register write
z80fi_mem_rd / z80fi_mem_raddr / z80fi_mem_rdata  out  1/16/8  first data read
z80fi_mem_wr / z80fi_mem_waddr / z80fi_mem_wdata  out  1/16/8  data write
z80fi_error  out  1  sticky protocol violation

Behaviour:
- Reset: all outputs 0. Internal byte count 0. State IDLE.
- States: IDLE (count 0), COLLECT (count 1..MAX_LEN).
- IDLE + fetch_valid: byte goes to [7:0], pc_rdata <= fetch_pc, count <= 1, go to COLLECT.
- COLLECT + fetch_valid: byte goes to lane count, count++.
- Unused upper lanes output 0.
- Events (fetch/reg/mem) in the retire cycle belong to the retiring instruction.
- Retire: next cycle z80fi_valid=1 with all captured fields and z80fi_pc_wdata=retire_next_pc. Latency is 1 cycle, registered outputs.
- After retire, all capture registers clear to 0 and state returns to IDLE. The next instruction's first fetch is legal in the cycle after retire.
- z80fi_valid is high for exactly one cycle per retire. All other packet outputs are 0 when valid is low.
- Register write and memory write: first event is captured. A second event before retire sets z80fi_error and keeps the first value.
- Memory read: first event is captured. A second read sets z80fi_error, unless the Optional Feature applies.
- Fetch with count==MAX_LEN: sets error, byte dropped, count saturates.
- Retire in IDLE with no fetch this cycle: sets error, no packet emitted.
- Error is sticky until reset.
- Reset mid-instruction: partial instruction discarded, no packet.
- Reset in the cycle after retire suppresses that packet.

Optional Feature:
Z80FI_MEM_RD2_EN
- Defined: adds ports z80fi_mem_rd2 (out 1), z80fi_mem_raddr2 (out 16) and z80fi_mem_rdata2 (out 8).
- Defined: the second data read is captured there. A third read sets error.
- Undefined: those ports are absent, and the second read sets error.

Decomposition:
- Shared z80fi package holds: MAX_LEN, insn width 32, register-number constants (the pair encoding {2'b10,dd} for BC/DE/HL/SP), and the state enum.
- One natural sub-module, z80fi_insn_accum: the byte-lane accumulator with count, saturation and overflow flag.

Test Plan:
- Fetch 01,34,12 at pc 0x0100,0x0101,0x0102; reg write num 4'b1000 data 0x1234; retire with next_pc 0x0103 -> next cycle valid=1, insn=0x00123401, len=3, pc_rdata=0x0100, pc_wdata=0x0103, reg_wr=1, wnum=8, wdata=0x1234, error=0.
- Single fetch 00 with retire in the same cycle, next_pc 0x0201 -> valid=1, len=1, insn=0x00000000, no reg/mem flags.
- Five fetches DD,CB,05,C6,xx before retire -> len=4, insn=0xC605CBDD, error=1.
- Two mem writes (0x8000/0xAA, 0x8001/0xBB) then retire -> waddr=0x8000, wdata=0xAA, error=1.
- Back-to-back: retire at cycle N, new fetch at N+1 -> two packets, second pc_rdata correct, no field leakage from the first.
- Reset asserted two cycles after the first fetch, then retire -> no valid pulse, all outputs 0, error=0.
